// File: rtl/reg_file.sv
// Register file: DEPTH x 32-bit registers, two combinational read ports,
// one write port, hard-wired zero register and optional write forwarding.
module reg_file #(
    parameter int DEPTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Ra,
    input  logic [4:0]  Rb,
    input  logic [4:0]  Rw,
    input  logic        RegWr,
    input  logic [31:0] busW,
    output logic [31:0] busA,
    output logic [31:0] busB
);

    // Register 0 has no storage; it is synthesised as a constant zero.
    logic [31:0] regs [1:DEPTH-1];
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        wr_en;
    logic        fwd_a;
    logic        fwd_b;

    // A write only counts when it targets a real, non-zero register
    // outside of reset; forwarding uses the same qualifier.
    assign wr_en = RegWr && !rst && (Rw != 5'd0)
                   && ({27'd0, Rw} < DEPTH);

    assign fwd_a = BYPASS && wr_en && (Ra == Rw);
    assign fwd_b = BYPASS && wr_en && (Rb == Rw);

    // Read muxes: out-of-range indices and index 0 fall through to zero.
    always_comb begin
        rdata_a = 32'h0;
        rdata_b = 32'h0;
        for (int i = 1; i < DEPTH; i++) begin
            if (Ra == 5'(i)) rdata_a = regs[i];
            if (Rb == 5'(i)) rdata_b = regs[i];
        end
    end

    assign busA = fwd_a ? busW : rdata_a;
    assign busB = fwd_b ? busW : rdata_b;

    // Storage update: reset clears everything and wins over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) regs[i] <= 32'h0;
        end else if (wr_en) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (Rw == 5'(i)) regs[i] <= busW;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed and model-based checks for reg_file with forwarding on/off
// and a reduced-depth instance.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra, rb, rw;
    logic        regwr;
    logic [31:0] busw;
    logic [31:0] a1, b1, a0, b0, a16, b16;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] m [32];
    int cover_hits = 0;

    always #5 clk = ~clk;

    reg_file #(.DEPTH(32), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw),
        .RegWr(regwr), .busW(busw), .busA(a1), .busB(b1)
    );

    reg_file #(.DEPTH(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw),
        .RegWr(regwr), .busW(busw), .busA(a0), .busB(b0)
    );

    reg_file #(.DEPTH(16), .BYPASS(1'b1)) dut16 (
        .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw),
        .RegWr(regwr), .busW(busw), .busA(a16), .busB(b16)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive a vector just after the falling edge, then let it settle.
    task automatic drive(input logic r, input logic we, input logic [4:0] w,
                         input logic [31:0] d, input logic [4:0] x,
                         input logic [4:0] y);
        @(negedge clk);
        rst = r; regwr = we; rw = w; busw = d; ra = x; rb = y;
        #1;
    endtask

    initial begin
        logic [31:0] ea, eb;
        rst = 1'b1; regwr = 1'b0; rw = '0; busw = '0; ra = '0; rb = '0;

        // Reset, then sweep every index on all instances.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
            check("rst_sweep_a", a1, 32'h0);
            check("rst_sweep_b", b1, 32'h0);
            check("rst_sweep_nb_a", a0, 32'h0);
            check("rst_sweep_16_a", a16, 32'h0);
        end

        // Write DEADBEEF to r5 with same-cycle read.
        drive(0, 1, 5, 32'hDEADBEEF, 5, 6);
        check("byp_a_r5", a1, 32'hDEADBEEF);
        check("nobyp_a_r5", a0, 32'h0);
        check("byp_b_r6", b1, 32'h0);
        drive(0, 0, 0, 0, 5, 5);
        check("r5_a", a1, 32'hDEADBEEF);
        check("r5_b", b1, 32'hDEADBEEF);
        check("r5_nb_a", a0, 32'hDEADBEEF);
        check("r5_nb_b", b0, 32'hDEADBEEF);

        // Write to r0 is ignored, including for forwarding.
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0);
        check("r0_byp_a", a1, 32'h0);
        check("r0_byp_b", b1, 32'h0);
        drive(0, 0, 0, 0, 0, 5);
        check("r0_after", a1, 32'h0);
        check("r5_kept", b1, 32'hDEADBEEF);

        // Forwarding on r7 versus old value with bypass disabled.
        drive(0, 1, 7, 32'h1, 0, 0);
        drive(0, 1, 7, 32'h2, 7, 7);
        check("r7_byp_a", a1, 32'h2);
        check("r7_byp_b", b1, 32'h2);
        check("r7_nobyp_a", a0, 32'h1);
        check("r7_nobyp_b", b0, 32'h1);
        drive(0, 0, 0, 0, 7, 7);
        check("r7_after", a1, 32'h2);
        check("r7_nb_after", a0, 32'h2);

        // Reset beats a concurrent write and clears everything.
        drive(0, 1, 3, 32'h55, 0, 0);
        drive(0, 0, 0, 0, 3, 3);
        check("r3_55", a1, 32'h55);
        drive(1, 1, 3, 32'hAA, 3, 3);
        check("rst_nobyp_a", a1, 32'h55);
        check("rst_nobyp_b", b1, 32'h55);
        drive(0, 0, 0, 0, 3, 5);
        check("r3_cleared", a1, 32'h0);
        check("r5_cleared", b1, 32'h0);
        drive(0, 0, 0, 0, 7, 7);
        check("r7_cleared", a1, 32'h0);
        check("r7_nb_cleared", a0, 32'h0);

        // Reduced depth: index >= 16 holds nothing, r15 works.
        drive(0, 1, 20, 32'h12345678, 0, 0);
        drive(0, 1, 15, 32'hCAFEF00D, 0, 0);
        drive(0, 0, 0, 0, 20, 15);
        check("d16_oor_a", a16, 32'h0);
        check("d16_r15_b", b16, 32'hCAFEF00D);
        check("d32_r20_a", a1, 32'h12345678);

        // Model-based regression on the full-depth forwarding instance.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        for (int c = 0; c < 10000; c++) begin
            logic        r, we;
            logic [4:0]  w, x, y;
            logic [31:0] d;
            r  = ($urandom_range(0, 499) == 0);
            we = $urandom_range(0, 3) != 0;
            d  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                w = 5'($urandom_range(0, 3));
                x = 5'($urandom_range(0, 3));
                y = 5'($urandom_range(0, 3));
            end else begin
                w = 5'($urandom);
                x = 5'($urandom);
                y = 5'($urandom);
            end
            drive(r, we, w, d, x, y);
            if (!r) begin
                ea = (we && w != 0 && x == w) ? d : m[x];
                eb = (we && w != 0 && y == w) ? d : m[y];
                check("rand_a", a1, ea);
                check("rand_b", b1, eb);
                if (we && w != 0 && x == w && y == w) cover_hits++;
            end
            if (r) begin
                for (int i = 0; i < 32; i++) m[i] = 32'h0;
            end else if (we && w != 0) begin
                m[w] = d;
            end
        end
        check("cover_ra_rb_rw", 32'(cover_hits != 0), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
